// File: rtl/morse_pkg.sv
// Symbol codes and FSM state type shared between the key sequencer and the Morse decoder.
package morse_pkg;

  localparam logic [1:0] MORSE_DOT  = 2'b01;
  localparam logic [1:0] MORSE_DASH = 2'b10;
  localparam logic [1:0] MORSE_EOC  = 2'b00;
  localparam logic [1:0] MORSE_NOP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP
  } state_e;

endpackage

// File: rtl/morse_unit_timer.sv
// Times marks and gaps in whole Morse units: a prescaler produces one tick per unit,
// and a saturating counter accumulates ticks since the last key edge.
module morse_unit_timer #(
  parameter int unsigned CLK_PER_UNIT = 1000,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] unit_cnt_o
);

  localparam int unsigned PRE_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] unit_q, unit_d;

  assign tick_o     = (pre_q == PRE_W'(CLK_PER_UNIT - 1));
  assign unit_cnt_o = unit_q;

  // A key edge restarts timing and swallows any tick landing in the same cycle.
  always_comb begin
    pre_d  = pre_q;
    unit_d = unit_q;
    if (clear_i) begin
      pre_d  = '0;
      unit_d = '0;
    end else if (tick_o) begin
      pre_d = '0;
      if (unit_q != '1) begin
        unit_d = unit_q + CNT_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      unit_q <= '0;
    end else begin
      pre_q  <= pre_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Straight-key front end: synchronises the key, classifies marks as dot/dash and
// issues one-cycle symbol codes to the Morse decoder, bounding characters at MAX_ELEMS.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned CLK_PER_UNIT   = 1000,
  parameter int unsigned DASH_UNITS     = 2,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned MAX_ELEMS      = 6,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       enable,
  output logic [1:0] morse_signal,
  output logic [2:0] elem_count,
  output logic       char_end,
  output logic       overflow,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   key_d_q;
  logic                   armed_q;
  logic                   key_s;
  logic                   rise;
  logic                   fall;

  logic                   tick;
  logic [CNT_W-1:0]       unit_cnt;
  logic [CNT_W:0]         unit_nxt;
  logic                   gap_done;

  state_e                 state_q, state_d;
  logic [1:0]             code_q, code_d;
  logic [2:0]             ec_q, ec_d;
  logic                   ce_q, ce_d;
  logic                   ov_q, ov_d;

  assign key_s = sync_q[SYNC_STAGES-1];

  // A key already held through reset must be seen released (after the synchroniser
  // has filled) before a press is accepted, so no stale mark is ever emitted.
  assign rise = key_s & ~key_d_q & armed_q;
  assign fall = ~key_s & key_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      key_d_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_in};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      key_d_q <= key_s;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~key_s);
    end
  end

  morse_unit_timer #(
    .CLK_PER_UNIT(CLK_PER_UNIT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (key_s ^ key_d_q),
    .tick_o    (tick),
    .unit_cnt_o(unit_cnt)
  );

  // The character closes on the tick that brings the gap to CHAR_GAP_UNITS.
  assign unit_nxt = {1'b0, unit_cnt} + (CNT_W+1)'(1);
  assign gap_done = tick && (unit_nxt >= (CNT_W+1)'(CHAR_GAP_UNITS));

  always_comb begin
    state_d = state_q;
    code_d  = MORSE_NOP;
    ce_d    = 1'b0;
    ov_d    = 1'b0;
    ec_d    = ec_q;
    if (!enable) begin
      state_d = IDLE;
      if (ec_q != 3'd0) begin
        code_d = MORSE_EOC;
        ce_d   = 1'b1;
        ec_d   = 3'd0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) state_d = MARK;
        end
        MARK: begin
          if (fall) begin
            code_d  = (unit_cnt < CNT_W'(DASH_UNITS)) ? MORSE_DOT : MORSE_DASH;
            ec_d    = ec_q + 3'd1;
            state_d = GAP;
          end
        end
        GAP: begin
          if (rise) begin
            state_d = MARK;
            if (ec_q >= 3'(MAX_ELEMS)) begin
              code_d = MORSE_EOC;
              ce_d   = 1'b1;
              ov_d   = 1'b1;
              ec_d   = 3'd0;
            end
          end else if (gap_done) begin
            code_d  = MORSE_EOC;
            ce_d    = 1'b1;
            ec_d    = 3'd0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= MORSE_NOP;
      ec_q    <= 3'd0;
      ce_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ec_q    <= ec_d;
      ce_q    <= ce_d;
      ov_q    <= ov_d;
    end
  end

  assign morse_signal = code_q;
  assign elem_count   = ec_q;
  assign char_end     = ce_q;
  assign overflow     = ov_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with a small prescaler; every non-idle output
// cycle is logged with its cycle number and checked against hand-computed sequences.
module tb_morse_key_sequencer;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       key_in = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] morse_signal;
  logic [2:0] elem_count;
  logic       char_end;
  logic       overflow;
  logic       busy;

  int unsigned tests_run = 0;
  int unsigned fails     = 0;
  int unsigned cyc       = 0;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  code;
    logic        ce;
    logic        ov;
    logic [2:0]  ec;
  } ev_t;

  ev_t evq[$];

  morse_key_sequencer #(
    .CLK_PER_UNIT  (4),
    .DASH_UNITS    (2),
    .CHAR_GAP_UNITS(3),
    .MAX_ELEMS     (6),
    .SYNC_STAGES   (2),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .enable      (enable),
    .morse_signal(morse_signal),
    .elem_count  (elem_count),
    .char_end    (char_end),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (morse_signal !== 2'b11 || char_end !== 1'b0 || overflow !== 1'b0)
      evq.push_back('{cyc: cyc, code: morse_signal, ce: char_end, ov: overflow, ec: elem_count});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; key_in = 1'b0;
    cycles(3);
    tests_run++;
    if (morse_signal !== 2'b11) begin fails++; $display("FAIL reset_code got=%b exp=11", morse_signal); end
    tests_run++;
    if (elem_count !== 3'd0) begin fails++; $display("FAIL reset_elem got=%0d exp=0", elem_count); end
    tests_run++;
    if ({char_end, overflow, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {char_end, overflow, busy});
    end
    rst_n = 1'b1; enable = 1'b1;
    cycles(6);
    evq.delete();
  endtask

  task automatic test_dot_end();
    evq.delete();
    key_in = 1'b1; cycles(5);
    key_in = 1'b0; cycles(25);
    tests_run++;
    if (evq.size() !== 2) begin fails++; $display("FAIL dot_count got=%0d exp=2", evq.size()); end
    tests_run++;
    if ({evq[0].code, evq[0].ce, evq[0].ov, evq[0].ec} !== {2'b01, 1'b0, 1'b0, 3'd1}) begin
      fails++; $display("FAIL dot_sym got=%b/%b/%b/%0d exp=01/0/0/1", evq[0].code, evq[0].ce, evq[0].ov, evq[0].ec);
    end
    tests_run++;
    if ({evq[1].code, evq[1].ce, evq[1].ov, evq[1].ec} !== {2'b00, 1'b1, 1'b0, 3'd0}) begin
      fails++; $display("FAIL dot_eoc got=%b/%b/%b/%0d exp=00/1/0/0", evq[1].code, evq[1].ce, evq[1].ov, evq[1].ec);
    end
    tests_run++;
    if (evq[1].cyc - evq[0].cyc !== 12) begin
      fails++; $display("FAIL dot_gap_timing got=%0d exp=12", evq[1].cyc - evq[0].cyc);
    end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL dot_busy got=%b exp=0", busy); end
  endtask

  task automatic test_letter_a();
    logic [1:0] exp_code [3] = '{2'b01, 2'b10, 2'b00};
    logic [2:0] exp_ec   [3] = '{3'd1, 3'd2, 3'd0};
    logic       exp_ce   [3] = '{1'b0, 1'b0, 1'b1};
    evq.delete();
    key_in = 1'b1; cycles(4);
    key_in = 1'b0; cycles(4);
    key_in = 1'b1; cycles(12);
    key_in = 1'b0; cycles(25);
    tests_run++;
    if (evq.size() !== 3) begin fails++; $display("FAIL a_count got=%0d exp=3", evq.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({evq[i].code, evq[i].ce, evq[i].ov, evq[i].ec} !== {exp_code[i], exp_ce[i], 1'b0, exp_ec[i]}) begin
        fails++;
        $display("FAIL a_ev%0d got=%b/%b/%b/%0d exp=%b/%b/0/%0d", i, evq[i].code, evq[i].ce, evq[i].ov,
                 evq[i].ec, exp_code[i], exp_ce[i], exp_ec[i]);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL a_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_code [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [2:0] exp_ec   [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd0};
    logic       exp_ce   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_ov   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    evq.delete();
    for (int i = 0; i < 7; i++) begin
      key_in = 1'b1; cycles(4);
      key_in = 1'b0; cycles(4);
    end
    cycles(20);
    tests_run++;
    if (evq.size() !== 9) begin fails++; $display("FAIL ovf_count got=%0d exp=9", evq.size()); end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if ({evq[i].code, evq[i].ce, evq[i].ov, evq[i].ec} !== {exp_code[i], exp_ce[i], exp_ov[i], exp_ec[i]}) begin
        fails++;
        $display("FAIL ovf_ev%0d got=%b/%b/%b/%0d exp=%b/%b/%b/%0d", i, evq[i].code, evq[i].ce, evq[i].ov,
                 evq[i].ec, exp_code[i], exp_ce[i], exp_ov[i], exp_ec[i]);
      end
    end
  endtask

  task automatic test_enable_flush();
    evq.delete();
    key_in = 1'b1; cycles(4);
    key_in = 1'b0; cycles(4);
    key_in = 1'b1; cycles(4);
    key_in = 1'b0; cycles(6);
    enable = 1'b0; cycles(4);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
    enable = 1'b1; cycles(20);
    tests_run++;
    if (evq.size() !== 3) begin fails++; $display("FAIL flush_count got=%0d exp=3", evq.size()); end
    tests_run++;
    if ({evq[1].code, evq[1].ec} !== {2'b01, 3'd2}) begin
      fails++; $display("FAIL flush_dot2 got=%b/%0d exp=01/2", evq[1].code, evq[1].ec);
    end
    tests_run++;
    if ({evq[2].code, evq[2].ce, evq[2].ov, evq[2].ec} !== {2'b00, 1'b1, 1'b0, 3'd0}) begin
      fails++; $display("FAIL flush_eoc got=%b/%b/%b/%0d exp=00/1/0/0", evq[2].code, evq[2].ce, evq[2].ov, evq[2].ec);
    end
  endtask

  task automatic test_enable_idle();
    evq.delete();
    key_in = 1'b1; cycles(6);
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL en_mark_busy got=%b exp=1", busy); end
    enable = 1'b0; cycles(3);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL en_drop_busy got=%b exp=0", busy); end
    enable = 1'b1; cycles(5);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL en_held_busy got=%b exp=0", busy); end
    key_in = 1'b0; cycles(20);
    tests_run++;
    if (evq.size() !== 0) begin fails++; $display("FAIL en_silent got=%0d codes exp=0", evq.size()); end
  endtask

  task automatic test_reset_mid_mark();
    evq.delete();
    key_in = 1'b1; cycles(6);
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({morse_signal, busy, elem_count} !== {2'b11, 1'b0, 3'd0}) begin
      fails++; $display("FAIL rst_async got=%b/%b/%0d exp=11/0/0", morse_signal, busy, elem_count);
    end
    cycles(2);
    rst_n = 1'b1; cycles(6);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_held_busy got=%b exp=0", busy); end
    key_in = 1'b0; cycles(25);
    tests_run++;
    if (evq.size() !== 0) begin fails++; $display("FAIL rst_no_code got=%0d codes exp=0", evq.size()); end
  endtask

  task automatic test_saturation();
    evq.delete();
    key_in = 1'b1; cycles(1500);
    tests_run++;
    if (dut.u_timer.unit_cnt_o !== 8'd255) begin
      fails++; $display("FAIL sat_1500 got=%0d exp=255", dut.u_timer.unit_cnt_o);
    end
    cycles(500);
    tests_run++;
    if (dut.u_timer.unit_cnt_o !== 8'd255) begin
      fails++; $display("FAIL sat_2000 got=%0d exp=255", dut.u_timer.unit_cnt_o);
    end
    key_in = 1'b0; cycles(25);
    tests_run++;
    if (evq.size() !== 2) begin fails++; $display("FAIL sat_count got=%0d exp=2", evq.size()); end
    tests_run++;
    if ({evq[0].code, evq[0].ec} !== {2'b10, 3'd1}) begin
      fails++; $display("FAIL sat_dash got=%b/%0d exp=10/1", evq[0].code, evq[0].ec);
    end
    tests_run++;
    if ({evq[1].code, evq[1].ce, evq[1].ec} !== {2'b00, 1'b1, 3'd0}) begin
      fails++; $display("FAIL sat_eoc got=%b/%b/%0d exp=00/1/0", evq[1].code, evq[1].ce, evq[1].ec);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dot_end();
    test_letter_a();
    test_overflow();
    test_enable_flush();
    test_enable_idle();
    test_reset_mid_mark();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/morse_key_sequencer.md
Name: morse_key_sequencer

Overview:
- Front-end controller for the Morse decoder datapath.
- Samples a raw straight-key level, times each mark and gap in Morse units, and classifies marks as dot or dash.
- Issues one-cycle symbol codes on the decoder's 2-bit symbol bus: dot 01, dash 10, end-of-character 00; drives 11 (no-op) at all other times.
- Enforces the 6-element character limit so the decoder's sequence register never overflows.

Parameters:
- CLK_PER_UNIT, 1000: clk cycles per Morse unit (prescaler period).
- DASH_UNITS, 2: mark of at least this many whole units is a dash; shorter is a dot.
- CHAR_GAP_UNITS, 3: gap of this many units ends the character.
- MAX_ELEMS, 6: maximum elements per character.
- SYNC_STAGES, 2: synchroniser depth on key_in (minimum 2).
- CNT_W, 8: width of the unit counter; saturates, never wraps.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- key_in, input, 1: raw key level, asynchronous, 1 = key down; debounced upstream.
- enable, input, 1: 1 = run; 0 = flush and idle.
- morse_signal, output, 2: symbol code to the decoder; registered.
- elem_count, output, 3: number of elements emitted for the current character.
- char_end, output, 1: one-cycle pulse coincident with morse_signal = 00.
- overflow, output, 1: one-cycle pulse when a character boundary is forced by MAX_ELEMS.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset values: morse_signal = 11, elem_count = 0, char_end = 0, overflow = 0, busy = 0, state IDLE, all counters 0, sync flops 0.
- Reset asserted mid-operation: all outputs return to reset values immediately. No pending symbol is ever emitted afterwards.
- Synchroniser and edge detect:
  - key_in passes through SYNC_STAGES flops to key_s; key_d is key_s delayed by one cycle.
  - rise = key_s & ~key_d; fall = ~key_s & key_d.
  - All outputs are registered. A code appears SYNC_STAGES+1 clk edges after the first edge that samples the new key_in level.
- Unit timer:
  - Prescaler counts 0..CLK_PER_UNIT-1. tick is asserted on the wrap cycle.
  - Prescaler and unit counter clear on every rise or fall; a tick in the same cycle as an edge is discarded.
  - Unit counter increments on each tick and saturates at 2^CNT_W-1.
- Default every cycle: morse_signal = 11, char_end = 0, overflow = 0.
- IDLE: on rise -> MARK.
- MARK, on fall:
  - units < DASH_UNITS emits 01; otherwise emits 10.
  - elem_count is incremented; next state GAP.
  - A press shorter than one unit (units = 0) is a dot.
- GAP:
  - units reaches CHAR_GAP_UNITS: emit 00, pulse char_end, clear elem_count, go to IDLE.
  - rise with elem_count < MAX_ELEMS: go to MARK, no output.
  - rise with elem_count = MAX_ELEMS: in the same cycle emit 00, pulse char_end and overflow, clear elem_count, go to MARK. The new press starts the next character.
- enable low:
  - Sampled every cycle and takes priority over all transitions.
  - If elem_count > 0: emit a single 00 with char_end, clear elem_count, go to IDLE. Otherwise go to IDLE silently.
  - While low, state stays IDLE and edges are ignored.
  - Key held down when enable rises: no mark until the next rise.
- Only one non-11 code is issued per cycle. At least one 11 cycle separates consecutive codes.

Decomposition:
- Shared package morse_pkg:
  - Code constants MORSE_DOT = 01, MORSE_DASH = 10, MORSE_EOC = 00, MORSE_NOP = 11.
  - State enum {IDLE, MARK, GAP}.
  - These constants are shared with the decoder.
- One sub-module: morse_unit_timer, containing the prescaler, tick generation, edge-clear and the saturating unit counter.
- The FSM, synchroniser and output registers stay in the top module.

Test Plan:
(All scenarios use CLK_PER_UNIT = 4, DASH_UNITS = 2, CHAR_GAP_UNITS = 3, MAX_ELEMS = 6.)
- Dot then end: key down 5 cycles, up 20 -> one 01 pulse; 00 with char_end exactly 12 cycles after fall detect; elem_count goes 1 then 0.
- "A" (.-): down 4, up 4, down 12, up 20 -> 01, then 10, then 00; elem_count 1, 2, 0; busy low after the 00.
- Overflow: seven dots, each down 4 / up 4 -> six 01 pulses; on the 7th rise 00 with char_end and overflow in the same cycle; then 01, then 00 after the gap.
- Enable flush: enable dropped during GAP after "..": one 00 with char_end, then IDLE. enable dropped with elem_count = 0: no code at all.
- Reset mid-MARK: rst_n low for 2 cycles while the key is held -> morse_signal = 11, busy = 0; the later release produces no code.
- Saturation: key held 2000 cycles -> single 10 on release; unit counter holds 255 without wrapping.
